systolic_skew_feeder: RTL and testbench



---
 rtl/systolic_skew_feeder.sv | 157 +++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: accepts one N-lane column vector per handshake and
// re-emits it diagonally skewed (lane i delayed i extra cycles) for the LU
// systolic array, framing vectors into matrices and reporting frame length.
module systolic_skew_feeder #(
    parameter int unsigned SZ = 8,
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*SZ-1:0] in_data,
    input  logic            in_last,
    output logic [N*SZ-1:0] lane_data,
    output logic [N-1:0]    lane_valid,
    output logic            frame_done,
    output logic [CW-1:0]   frame_len
);

    // Drain counter needs to hold N-2 (at least one bit so N=1,2 stay legal)
    localparam int unsigned DW = (N > 2) ? $clog2(N) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'((N > 1) ? (N - 2) : 0);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [DW-1:0] r_dcnt;
    logic [DW-1:0] w_dcnt_nxt;
    logic          r_ready;
    logic          w_ready_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_len;
    logic          w_xfer;
    logic          w_xfer_last;

    assign w_xfer      = in_valid & r_ready;
    assign w_xfer_last = w_xfer & in_last;
    // Length of the frame closed by this transfer, including the transfer itself
    assign w_len       = r_cnt + CW'(1);

    // Next-state: frame tracking and the N-1 cycle skew drain after a last vector
    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        case (r_state)
            ST_IDLE, ST_STREAM: begin
                if (w_xfer) begin
                    if (in_last) begin
                        if (N > 1) begin
                            w_state_nxt = ST_DRAIN;
                            w_dcnt_nxt  = DRAIN_INIT;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_state_nxt = ST_STREAM;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_dcnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_dcnt_nxt = r_dcnt - DW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_dcnt_nxt  = '0;
            end
        endcase
        w_ready_nxt = (w_state_nxt != ST_DRAIN);
    end

    // State register; ready is registered alongside so it rises one cycle after reset release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_dcnt  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Vector counter for the current frame; wraps naturally modulo 2^CW
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_cnt <= in_last ? '0 : w_len;
        end
    end

    assign in_ready = r_ready;

    // Per-lane skew pipelines: lane i is i+1 registers deep, bubbles carry zero data
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [SZ-1:0] r_d [i+1];
        logic          r_v [i+1];

        // Shift the lane element and its valid flag one stage per cycle
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int j = 0; j < i + 1; j++) begin
                    r_d[j] <= '0;
                    r_v[j] <= 1'b0;
                end
            end else begin
                r_d[0] <= w_xfer ? in_data[i*SZ +: SZ] : '0;
                r_v[0] <= w_xfer;
                for (int j = 1; j < i + 1; j++) begin
                    r_d[j] <= r_d[j-1];
                    r_v[j] <= r_v[j-1];
                end
            end
        end

        assign lane_data[i*SZ +: SZ] = r_d[i];
        assign lane_valid[i]         = r_v[i];
    end

    // Last-flag and length travel with lane N-1; length stages hold between frames
    logic          r_last_sh [N];
    logic [CW-1:0] r_len_sh  [N];

    // Frame completion pipeline matched to the deepest lane
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                r_last_sh[k] <= 1'b0;
                r_len_sh[k]  <= '0;
            end
        end else begin
            r_last_sh[0] <= w_xfer_last;
            if (w_xfer_last) begin
                r_len_sh[0] <= w_len;
            end
            for (int k = 1; k < N; k++) begin
                r_last_sh[k] <= r_last_sh[k-1];
                if (r_last_sh[k-1]) begin
                    r_len_sh[k] <= r_len_sh[k-1];
                end
            end
        end
    end

    assign frame_done = r_last_sh[N-1];
    assign frame_len  = r_len_sh[N-1];

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed self-checking bench for systolic_skew_feeder (N=4 main instance,
// plus a CW=2 instance for counter wrap and an N=1 instance for back-to-back).
module tb_systolic_skew_feeder;

    logic clk;
    logic rst_n;
    logic rst_aux_n;

    // Main DUT: SZ=8, N=4, CW=8
    logic        in_valid, in_ready, in_last, frame_done;
    logic [31:0] in_data, lane_data;
    logic [3:0]  lane_valid;
    logic [7:0]  frame_len;

    // Wrap DUT: SZ=8, N=4, CW=2
    logic        c_valid, c_ready, c_last, c_done;
    logic [31:0] c_data, c_lane_data;
    logic [3:0]  c_lane_valid;
    logic [1:0]  c_len;

    // Single-lane DUT: SZ=8, N=1, CW=8
    logic        n_valid, n_ready, n_last, n_done;
    logic [7:0]  n_data, n_lane_data;
    logic [0:0]  n_lane_valid;
    logic [7:0]  n_len;

    int n_tests;
    int n_fail;

    // Per-test stimulus schedule and transfer history for the lane model
    logic [31:0] sv_data  [32];
    logic        sv_valid [32];
    logic        sv_last  [32];
    logic [7:0]  sv_len   [32];
    logic [31:0] hist_d   [32];
    logic        hist_v   [32];
    logic [7:0]  exp_len;

    systolic_skew_feeder #(.SZ(8), .N(4), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .lane_data(lane_data),
        .lane_valid(lane_valid), .frame_done(frame_done), .frame_len(frame_len)
    );

    systolic_skew_feeder #(.SZ(8), .N(4), .CW(2)) dut_cw2 (
        .clk(clk), .rst_n(rst_aux_n), .in_valid(c_valid), .in_ready(c_ready),
        .in_data(c_data), .in_last(c_last), .lane_data(c_lane_data),
        .lane_valid(c_lane_valid), .frame_done(c_done), .frame_len(c_len)
    );

    systolic_skew_feeder #(.SZ(8), .N(1), .CW(8)) dut_n1 (
        .clk(clk), .rst_n(rst_aux_n), .in_valid(n_valid), .in_ready(n_ready),
        .in_data(n_data), .in_last(n_last), .lane_data(n_lane_data),
        .lane_valid(n_lane_valid), .frame_done(n_done), .frame_len(n_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane i after edge e shows whatever was transferred at edge e-i
    function automatic logic [3:0] f_exp_v(input int e);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (e - i >= 0 && hist_v[e-i]) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] f_exp_d(input int e);
        logic [31:0] r;
        logic [31:0] v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (e - i >= 0 && hist_v[e-i]) begin
                v = hist_d[e-i];
                r[i*8 +: 8] = v[i*8 +: 8];
            end
        end
        return r;
    endfunction

    task automatic clear_sched();
        for (int e = 0; e < 32; e++) begin
            sv_data[e]  = '0;
            sv_valid[e] = 1'b0;
            sv_last[e]  = 1'b0;
            sv_len[e]   = '0;
            hist_d[e]   = '0;
            hist_v[e]   = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_aux_n = 1'b0;
        in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b1;
        c_valid = 1'b1; c_data = 32'h12345678; c_last = 1'b0;
        n_valid = 1'b1; n_data = 8'h5A; n_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (in_ready !== 1'b0 || lane_valid !== 4'h0 || lane_data !== 32'h0 ||
                frame_done !== 1'b0 || frame_len !== 8'h0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got rdy=%b v=%b d=%h done=%b len=%h expected all 0",
                         k, in_ready, lane_valid, lane_data, frame_done, frame_len);
            end
        end
        n_tests++;
        if (c_ready !== 1'b0 || n_ready !== 1'b0 || n_done !== 1'b0 || c_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_aux got c_rdy=%b n_rdy=%b n_done=%b c_done=%b expected 0",
                     c_ready, n_ready, n_done, c_done);
        end
        in_valid = 1'b0; c_valid = 1'b0; n_valid = 1'b0;
        rst_n = 1'b1; rst_aux_n = 1'b1;
        tick();
        n_tests++;
        if (in_ready !== 1'b1 || lane_valid !== 4'h0 || frame_done !== 1'b0 || frame_len !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_release got rdy=%b v=%b done=%b len=%h expected rdy=1 others 0",
                     in_ready, lane_valid, frame_done, frame_len);
        end
        n_tests++;
        if (c_ready !== 1'b1 || n_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_aux got c_rdy=%b n_rdy=%b expected 1", c_ready, n_ready);
        end
        exp_len = 8'h0;
    endtask

    task automatic test_single();
        logic [31:0] exp_rdy;
        logic [31:0] exp_done;
        logic        rdy_prev;
        clear_sched();
        sv_valid[0] = 1'b1; sv_data[0] = 32'h04030201; sv_last[0] = 1'b1; sv_len[0] = 8'd1;
        exp_rdy  = 32'b11000;
        exp_done = 32'b01000;
        sv_len[3] = 8'd1;
        rdy_prev = 1'b1;
        for (int e = 0; e < 5; e++) begin
            in_valid = sv_valid[e]; in_data = sv_data[e]; in_last = sv_last[e];
            hist_v[e] = sv_valid[e] && rdy_prev;
            hist_d[e] = sv_data[e];
            tick();
            rdy_prev = exp_rdy[e];
            if (exp_done[e]) exp_len = sv_len[e];
            n_tests++;
            if (lane_valid !== f_exp_v(e) || lane_data !== f_exp_d(e)) begin
                n_fail++;
                $display("FAIL single_lanes e=%0d got v=%b d=%h expected v=%b d=%h",
                         e, lane_valid, lane_data, f_exp_v(e), f_exp_d(e));
            end
            n_tests++;
            if (in_ready !== exp_rdy[e] || frame_done !== exp_done[e] || frame_len !== exp_len) begin
                n_fail++;
                $display("FAIL single_ctrl e=%0d got rdy=%b done=%b len=%0d expected rdy=%b done=%b len=%0d",
                         e, in_ready, frame_done, frame_len, exp_rdy[e], exp_done[e], exp_len);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] exp_rdy;
        logic [31:0] exp_done;
        logic        rdy_prev;
        clear_sched();
        for (int k = 0; k < 4; k++) begin
            sv_valid[k] = 1'b1;
            sv_data[k]  = 32'h40302010 + 32'h01010101 * 32'(k);
        end
        sv_last[3] = 1'b1;
        sv_len[6]  = 8'd4;
        exp_rdy  = 32'b11000111;
        exp_done = 32'b01000000;
        rdy_prev = 1'b1;
        for (int e = 0; e < 8; e++) begin
            in_valid = sv_valid[e]; in_data = sv_data[e]; in_last = sv_last[e];
            hist_v[e] = sv_valid[e] && rdy_prev;
            hist_d[e] = sv_data[e];
            tick();
            rdy_prev = exp_rdy[e];
            if (exp_done[e]) exp_len = sv_len[e];
            n_tests++;
            if (lane_valid !== f_exp_v(e) || lane_data !== f_exp_d(e)) begin
                n_fail++;
                $display("FAIL stream_lanes e=%0d got v=%b d=%h expected v=%b d=%h",
                         e, lane_valid, lane_data, f_exp_v(e), f_exp_d(e));
            end
            n_tests++;
            if (in_ready !== exp_rdy[e] || frame_done !== exp_done[e] || frame_len !== exp_len) begin
                n_fail++;
                $display("FAIL stream_ctrl e=%0d got rdy=%b done=%b len=%0d expected rdy=%b done=%b len=%0d",
                         e, in_ready, frame_done, frame_len, exp_rdy[e], exp_done[e], exp_len);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_gap_backpressure();
        logic [31:0] exp_rdy;
        logic [31:0] exp_done;
        logic        rdy_prev;
        clear_sched();
        sv_valid[0] = 1'b1; sv_data[0] = 32'hA3A2A1A0;
        sv_valid[1] = 1'b1; sv_data[1] = 32'hB3B2B1B0;
        sv_valid[4] = 1'b1; sv_data[4] = 32'hC3C2C1C0;
        sv_valid[5] = 1'b1; sv_data[5] = 32'hD3D2D1D0; sv_last[5] = 1'b1;
        // Next single-vector frame offered during the drain and held until accepted
        for (int e = 6; e < 10; e++) begin
            sv_valid[e] = 1'b1; sv_data[e] = 32'hE3E2E1E0; sv_last[e] = 1'b1;
        end
        sv_len[8]  = 8'd4;
        sv_len[12] = 8'd1;
        exp_rdy  = 32'b11000100011111;
        exp_done = 32'b01000100000000;
        rdy_prev = 1'b1;
        for (int e = 0; e < 14; e++) begin
            in_valid = sv_valid[e]; in_data = sv_data[e]; in_last = sv_last[e];
            hist_v[e] = sv_valid[e] && rdy_prev;
            hist_d[e] = sv_data[e];
            tick();
            rdy_prev = exp_rdy[e];
            if (exp_done[e]) exp_len = sv_len[e];
            n_tests++;
            if (lane_valid !== f_exp_v(e) || lane_data !== f_exp_d(e)) begin
                n_fail++;
                $display("FAIL gap_lanes e=%0d got v=%b d=%h expected v=%b d=%h",
                         e, lane_valid, lane_data, f_exp_v(e), f_exp_d(e));
            end
            n_tests++;
            if (in_ready !== exp_rdy[e] || frame_done !== exp_done[e] || frame_len !== exp_len) begin
                n_fail++;
                $display("FAIL gap_ctrl e=%0d got rdy=%b done=%b len=%0d expected rdy=%b done=%b len=%0d",
                         e, in_ready, frame_done, frame_len, exp_rdy[e], exp_done[e], exp_len);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        in_valid = 1'b1; in_data = 32'h77665544; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        n_tests++;
        if (lane_valid !== 4'b0001 || lane_data !== 32'h00000044 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL middrain_pre got v=%b d=%h rdy=%b expected v=0001 d=00000044 rdy=0",
                     lane_valid, lane_data, in_ready);
        end
        rst_n = 1'b0;
        tick();
        n_tests++;
        if (lane_valid !== 4'h0 || lane_data !== 32'h0 || in_ready !== 1'b0 ||
            frame_done !== 1'b0 || frame_len !== 8'h0) begin
            n_fail++;
            $display("FAIL middrain_rst got v=%b d=%h rdy=%b done=%b len=%h expected all 0",
                     lane_valid, lane_data, in_ready, frame_done, frame_len);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (in_ready !== 1'b1 || lane_valid !== 4'h0 || lane_data !== 32'h0 ||
                frame_done !== 1'b0 || frame_len !== 8'h0) begin
                n_fail++;
                $display("FAIL middrain_after cyc=%0d got rdy=%b v=%b d=%h done=%b len=%h expected rdy=1 others 0",
                         k, in_ready, lane_valid, lane_data, frame_done, frame_len);
            end
        end
    endtask

    task automatic test_cw_wrap();
        logic [8:0] exp_rdy;
        exp_rdy = 9'b110001111;
        for (int e = 0; e < 9; e++) begin
            c_valid = (e < 5);
            c_last  = (e == 4);
            c_data  = 32'h01010101 * 32'(e + 1);
            tick();
            n_tests++;
            if (c_ready !== exp_rdy[e] || c_done !== (e == 7)) begin
                n_fail++;
                $display("FAIL wrap_ctrl e=%0d got rdy=%b done=%b expected rdy=%b done=%b",
                         e, c_ready, c_done, exp_rdy[e], (e == 7));
            end
            if (e == 7) begin
                n_tests++;
                if (c_len !== 2'd1) begin
                    n_fail++;
                    $display("FAIL wrap_len got %0d expected 1", c_len);
                end
            end
        end
        c_valid = 1'b0;
    endtask

    task automatic test_n1_back_to_back();
        logic [7:0] exp_d;
        for (int k = 0; k < 6; k++) begin
            n_valid = 1'b1; n_last = 1'b1;
            n_data  = 8'hA0 + 8'(k);
            exp_d   = 8'hA0 + 8'(k);
            tick();
            n_tests++;
            if (n_ready !== 1'b1 || n_lane_valid !== 1'b1 || n_lane_data !== exp_d ||
                n_done !== 1'b1 || n_len !== 8'd1) begin
                n_fail++;
                $display("FAIL n1_b2b k=%0d got rdy=%b v=%b d=%h done=%b len=%0d expected rdy=1 v=1 d=%h done=1 len=1",
                         k, n_ready, n_lane_valid, n_lane_data, n_done, n_len, exp_d);
            end
        end
        n_valid = 1'b0; n_last = 1'b0;
        tick();
        n_tests++;
        if (n_ready !== 1'b1 || n_lane_valid !== 1'b0 || n_lane_data !== 8'h0 ||
            n_done !== 1'b0 || n_len !== 8'd1) begin
            n_fail++;
            $display("FAIL n1_idle got rdy=%b v=%b d=%h done=%b len=%0d expected rdy=1 v=0 d=00 done=0 len=1",
                     n_ready, n_lane_valid, n_lane_data, n_done, n_len);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; rst_aux_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        c_valid = 1'b0; c_data = '0; c_last = 1'b0;
        n_valid = 1'b0; n_data = '0; n_last = 1'b0;
        exp_len = '0;
        test_reset();
        test_single();
        test_stream();
        test_gap_backpressure();
        test_reset_mid_drain();
        test_cw_wrap();
        test_n1_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
